// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor geometry, timing defaults, state codes and SCAN decision
package elevator_pkg;
  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W = 3;
  localparam int TRAVEL_CYCLES_DEF = 16;
  localparam int DOOR_CYCLES_DEF = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_DOOR = 2'd3;
  function automatic logic [1:0] decide(input logic here, input logic above, input logic below, input logic dir_up);
    return here ? S_DOOR : ((dir_up && above) || (above && !below)) ? S_UP : below ? S_DOWN : S_IDLE;
  endfunction
endpackage

// File: rtl/elevator_call_scan.sv
// elevator_call_scan: classifies pending calls as at, above or below the current floor
module elevator_call_scan import elevator_pkg::*; (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic                  here_o,
  output logic                  above_o,
  output logic                  below_o
);
  logic [NUM_FLOORS-1:0] above_mask, below_mask;
  // Floor masks strictly above / below the car; out-of-range floors never appear
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = i > int'(cur_floor_i);
      below_mask[i] = i < int'(cur_floor_i);
    end
  end
  assign here_o = pending_i[cur_floor_i];
  assign above_o = |(pending_i & above_mask);
  assign below_o = |(pending_i & below_mask);
endmodule

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: collective (SCAN) car motion FSM with travel/door timers and call retire pulse
module elevator_car_ctrl import elevator_pkg::*; #(
  parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int DOOR_CYCLES = DOOR_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_inside,
  input  logic [NUM_FLOORS-1:0] call_outside,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  clear_valid,
  output logic [FLOOR_W-1:0]    clear_floor
);
  localparam int TMR_W = $clog2(TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES);
  localparam logic [TMR_W-1:0] TRAVEL_LD = TMR_W'(TRAVEL_CYCLES - 1);
  localparam logic [TMR_W-1:0] TRAVEL_RELD = TMR_W'(TRAVEL_CYCLES - 2);
  localparam logic [TMR_W-1:0] DOOR_LD = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  logic [1:0] state_q, state_d, dec, dec_close, nxt;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d, clear_floor_q, clear_floor_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0] age_q, age_d;
  logic dir_up_q, dir_up_d, moving_q, moving_d, door_open_q, door_open_d;
  logic clear_valid_q, clear_valid_d, arrive_q, arrive_d;
  logic here, above, below, in_move, hold, step, decide_now;
  elevator_call_scan u_scan (
    .pending_i  (call_inside | call_outside),
    .cur_floor_i(cur_floor_q),
    .here_o     (here),
    .above_o    (above),
    .below_o    (below)
  );
  assign in_move = state_q == S_UP || state_q == S_DOWN;
  assign dec = decide(here, above, below, dir_up_q);
  assign dec_close = decide(1'b0, above, below, dir_up_q);
  assign nxt = state_q == S_DOOR ? dec_close : dec;
  assign hold = state_q == S_DOOR && here && age_q == 2'd2;
  assign step = in_move && !arrive_q && tmr_q == '0;
  assign decide_now = state_q == S_IDLE || (in_move && arrive_q) || (state_q == S_DOOR && tmr_q == '0 && !hold);
  // Next state: SCAN decision, door hold after the retire has settled, or one-floor step
  always_comb begin
    state_d = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d = dir_up_q;
    tmr_d = tmr_q == '0 ? tmr_q : tmr_q - TMR_W'(1);
    arrive_d = 1'b0;
    clear_valid_d = 1'b0;
    clear_floor_d = clear_floor_q;
    age_d = age_q == 2'd2 ? age_q : age_q + 2'd1;
    if (decide_now) begin
      state_d = nxt;
      dir_up_d = nxt == S_UP ? 1'b1 : nxt == S_DOWN ? 1'b0 : dir_up_q;
      tmr_d = nxt == S_DOOR ? DOOR_LD : arrive_q ? TRAVEL_RELD : TRAVEL_LD;
      clear_valid_d = nxt == S_DOOR;
      clear_floor_d = nxt == S_DOOR ? cur_floor_q : clear_floor_q;
      age_d = 2'd0;
    end else if (hold) begin
      tmr_d = DOOR_LD;
      clear_valid_d = 1'b1;
      clear_floor_d = cur_floor_q;
      age_d = 2'd0;
    end else if (step) begin
      cur_floor_d = state_q == S_UP ? (cur_floor_q == TOP ? cur_floor_q : cur_floor_q + FLOOR_W'(1))
                                    : (cur_floor_q == '0 ? cur_floor_q : cur_floor_q - FLOOR_W'(1));
      arrive_d = 1'b1;
    end
    moving_d = state_d == S_UP || state_d == S_DOWN;
    door_open_d = state_d == S_DOOR;
  end
  // State and registered outputs; reset parks the car idle at floor 0 heading up
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_floor_q <= '0;
      dir_up_q <= 1'b1;
      moving_q <= 1'b0;
      door_open_q <= 1'b0;
      clear_valid_q <= 1'b0;
      clear_floor_q <= '0;
      tmr_q <= '0;
      age_q <= 2'd0;
      arrive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q <= dir_up_d;
      moving_q <= moving_d;
      door_open_q <= door_open_d;
      clear_valid_q <= clear_valid_d;
      clear_floor_q <= clear_floor_d;
      tmr_q <= tmr_d;
      age_q <= age_d;
      arrive_q <= arrive_d;
    end
  end
  assign cur_floor = cur_floor_q;
  assign dir_up = dir_up_q;
  assign moving = moving_q;
  assign door_open = door_open_q;
  assign clear_valid = clear_valid_q;
  assign clear_floor = clear_floor_q;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: directed self-checking bench with TRAVEL_CYCLES=4, DOOR_CYCLES=3
module tb_elevator_car_ctrl;
  logic clk, reset;
  logic [7:0] call_inside, call_outside;
  logic [2:0] cur_floor, clear_floor;
  logic dir_up, moving, door_open, clear_valid;
  int n_cmp = 0;
  int n_err = 0;
  int n;
  elevator_car_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .call_inside(call_inside), .call_outside(call_outside),
    .cur_floor(cur_floor), .dir_up(dir_up), .moving(moving), .door_open(door_open),
    .clear_valid(clear_valid), .clear_floor(clear_floor)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_door(output int c);
    c = 0;
    do begin
      step(1);
      c++;
    end while (door_open !== 1'b1 && c < 200);
  endtask
  initial begin
    reset = 1'b1;
    call_inside = '0;
    call_outside = '0;
    step(3);
    chk("rst_floor", cur_floor, 0);
    chk("rst_dir", dir_up, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_clr", clear_valid, 0);
    chk("rst_clr_floor", clear_floor, 0);
    reset = 1'b0;
    call_inside = 8'h01;
    step(1);
    chk("t1_door", door_open, 1);
    chk("t1_clr", clear_valid, 1);
    chk("t1_clr_floor", clear_floor, 0);
    call_inside = '0;
    step(1);
    chk("t1_clr_pulse", clear_valid, 0);
    chk("t1_door_c2", door_open, 1);
    step(1);
    chk("t1_door_c3", door_open, 1);
    step(1);
    chk("t1_door_closed", door_open, 0);
    chk("t1_idle", moving, 0);
    call_inside = 8'h20;
    step(1);
    chk("t2_moving", moving, 1);
    chk("t2_dir", dir_up, 1);
    chk("t2_floor0", cur_floor, 0);
    for (int k = 1; k <= 5; k++) begin
      step(4);
      chk("t2_floor", cur_floor, k);
      chk("t2_moving_dec", moving, 1);
    end
    step(1);
    chk("t2_door", door_open, 1);
    chk("t2_clr", clear_valid, 1);
    chk("t2_clr_floor", clear_floor, 5);
    chk("t2_stopped", moving, 0);
    call_inside = '0;
    step(3);
    chk("t2_door_closed", door_open, 0);
    call_outside = 8'h01;
    step(1);
    chk("dn_dir", dir_up, 0);
    chk("dn_moving", moving, 1);
    wait_door(n);
    chk("dn_latency", n, 21);
    chk("dn_floor", cur_floor, 0);
    chk("dn_clr_floor", clear_floor, 0);
    call_outside = '0;
    step(3);
    chk("dn_door_closed", door_open, 0);
    call_inside = 8'h40;
    step(1);
    chk("t4_dir", dir_up, 1);
    chk("t4_moving", moving, 1);
    step(5);
    chk("t4_floor1", cur_floor, 1);
    call_outside = 8'h04;
    wait_door(n);
    chk("t4_latency", n, 4);
    chk("t4_floor", cur_floor, 2);
    chk("t4_clr_floor", clear_floor, 2);
    chk("t4_clr", clear_valid, 1);
    call_outside = '0;
    step(3);
    chk("t3_door_closed", door_open, 0);
    chk("t3_resume", moving, 1);
    chk("t3_floor2", cur_floor, 2);
    call_outside = 8'h02;
    wait_door(n);
    chk("t3_latency_up", n, 17);
    chk("t3_floor6", cur_floor, 6);
    chk("t3_clr_floor6", clear_floor, 6);
    chk("t3_dir_up", dir_up, 1);
    call_inside = '0;
    step(3);
    chk("t3_reverse_moving", moving, 1);
    chk("t3_reverse_dir", dir_up, 0);
    chk("t3_reverse_door", door_open, 0);
    wait_door(n);
    chk("t3_latency_dn", n, 21);
    chk("t3_floor1", cur_floor, 1);
    chk("t3_clr_floor1", clear_floor, 1);
    chk("t3_clr", clear_valid, 1);
    call_outside = '0;
    step(2);
    chk("t5_door_before", door_open, 1);
    chk("t5_no_clr", clear_valid, 0);
    call_outside = 8'h02;
    step(1);
    chk("t5_reclr", clear_valid, 1);
    chk("t5_reclr_floor", clear_floor, 1);
    chk("t5_door_held", door_open, 1);
    call_outside = '0;
    step(2);
    chk("t5_door_ext", door_open, 1);
    chk("t5_clr_once", clear_valid, 0);
    step(1);
    chk("t5_door_closed", door_open, 0);
    chk("t5_idle", moving, 0);
    call_inside = 8'h80;
    step(14);
    chk("t6_floor4", cur_floor, 4);
    chk("t6_moving", moving, 1);
    reset = 1'b1;
    step(1);
    chk("t6_floor", cur_floor, 0);
    chk("t6_moving_rst", moving, 0);
    chk("t6_door", door_open, 0);
    chk("t6_clr", clear_valid, 0);
    chk("t6_dir", dir_up, 1);
    chk("t6_clr_floor", clear_floor, 0);
    reset = 1'b0;
    call_inside = '0;
    step(2);
    chk("t6_idle", moving, 0);
    chk("t6_idle_floor", cur_floor, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
